// File: rtl/memory_stage.sv
// Memory pipeline stage: bus initiator for loads/stores, passes ALU results through.
// Optional MEM_MISALIGN_CHECK_EN adds out_misalign and suppresses misaligned bus requests.
module memory_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_wa,
  input  logic            in_regwrite,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic [1:0]      in_msize,
  input  logic            in_unsigned,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_wa,
  output logic            out_regwrite
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic            out_misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  state_t          w_accept_state;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_wa;
  logic            r_regwrite;
  logic            r_memread;
  logic            r_memwrite;
  logic [1:0]      r_msize;
  logic            r_unsigned;

  logic            w_accept;
  logic            w_is_mem;
  logic            w_bad_align;
  logic            w_data_done;
  logic [7:0]      w_base;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_data;

  assign in_ready = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mem = in_memread || in_memwrite;

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misalign;
  logic w_misaligned;

  always_comb begin
    w_misaligned = 1'b0;
    case (in_msize)
      2'd1:    w_misaligned = in_result[0];
      2'd2:    w_misaligned = |in_result[1:0];
      2'd3:    w_misaligned = |in_result[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_bad_align  = w_is_mem && w_misaligned;
  assign out_misalign = r_misalign;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_misalign <= w_bad_align;
    end
  end
`else
  assign w_bad_align = 1'b0;
`endif

  assign w_accept_state = (w_is_mem && !w_bad_align) ? S_REQ : S_DONE;

  // Data phase ends either together with the address phase or later in WAIT.
  assign w_data_done = (r_state == S_REQ  && dresp_addr_ok && dresp_data_ok) ||
                       (r_state == S_WAIT && dresp_data_ok);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_accept_state;
      end
      S_REQ: begin
        if (dresp_addr_ok) w_state_next = dresp_data_ok ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (dresp_data_ok) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_next = in_valid ? w_accept_state : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_base = 8'h01;
    case (r_msize)
      2'd0:    w_base = 8'h01;
      2'd1:    w_base = 8'h03;
      2'd2:    w_base = 8'h0F;
      default: w_base = 8'hFF;
    endcase
  end

  assign dreq_valid  = (r_state == S_REQ);
  assign dreq_addr   = r_addr;
  assign dreq_size   = r_msize;
  assign dreq_strobe = r_memwrite ? (w_base << r_addr[2:0]) : 8'h00;
  assign dreq_data   = r_wdata << {r_addr[2:0], 3'b000};

  assign w_shifted = dresp_data >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_msize)
      2'd0:    w_load_data = {{(XLEN-8){w_shifted[7] & ~r_unsigned}}, w_shifted[7:0]};
      2'd1:    w_load_data = {{(XLEN-16){w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
      2'd2:    w_load_data = {{(XLEN-32){w_shifted[31] & ~r_unsigned}}, w_shifted[31:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // r_result starts as the ALU result and is overwritten only by load data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_result   <= '0;
      r_wa       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_msize    <= 2'd0;
      r_unsigned <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= in_pc;
      r_addr     <= in_result;
      r_wdata    <= in_wdata;
      r_result   <= in_result;
      r_wa       <= in_wa;
      r_regwrite <= in_regwrite && !w_bad_align;
      r_memread  <= in_memread;
      r_memwrite <= in_memwrite;
      r_msize    <= in_msize;
      r_unsigned <= in_unsigned;
    end else if (w_data_done && r_memread) begin
      r_result   <= w_load_data;
    end
  end

  assign out_valid    = (r_state == S_DONE);
  assign out_pc       = r_pc;
  assign out_result   = r_result;
  assign out_wa       = r_wa;
  assign out_regwrite = r_regwrite;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a byte-level reference model.
// Build with MEM_MISALIGN_CHECK_EN to also exercise out_misalign.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_result;
  logic [63:0] in_wdata;
  logic [4:0]  in_wa;
  logic        in_regwrite;
  logic        in_memread;
  logic        in_memwrite;
  logic [1:0]  in_msize;
  logic        in_unsigned;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_result;
  logic [4:0]  out_wa;
  logic        out_regwrite;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  int checks   = 0;
  int failures = 0;

  memory_stage #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_result(in_result),
    .in_wdata(in_wdata), .in_wa(in_wa), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_memwrite(in_memwrite), .in_msize(in_msize),
    .in_unsigned(in_unsigned),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_result(out_result), .out_wa(out_wa), .out_regwrite(out_regwrite)
`ifdef MEM_MISALIGN_CHECK_EN
    , .out_misalign(out_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte-lane view of the bus.
  function automatic logic [7:0] m_strobe(input logic [2:0] o, input logic [1:0] sz);
    logic [7:0] s = 8'h00;
    int n = 1 << sz;
    for (int k = 0; k < 8; k++)
      if (k >= int'(o) && k < int'(o) + n) s[k] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_sdata(input logic [63:0] wd, input logic [2:0] o);
    logic [63:0] r = 64'h0;
    for (int k = 0; k < 8; k++)
      if (k >= int'(o)) r[8*k +: 8] = wd[8*(k-int'(o)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] o,
                                         input logic [1:0] sz, input logic uns);
    logic [63:0] v = 64'h0;
    int n = 1 << sz;
    for (int b = 0; b < n; b++)
      if (int'(o) + b < 8) v[8*b +: 8] = rd[8*(int'(o)+b) +: 8];
    if (!uns && sz != 2'd3 && v[8*n-1])
      for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  // kind: 0 = ALU, 1 = load, 2 = store
  task automatic drive(input int kind, input logic [1:0] sz, input logic uns,
                       input logic [63:0] pc, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [4:0] wa, input logic rw);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_result   = addr;
    in_wdata    = wd;
    in_wa       = wa;
    in_regwrite = rw;
    in_memread  = (kind == 1);
    in_memwrite = (kind == 2);
    in_msize    = sz;
    in_unsigned = uns;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_resp();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = {$urandom, $urandom};
  endtask

  task automatic run_txn(input int kind, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input int a_dly, input int d_dly, input int bp);
    logic [63:0] pc  = {$urandom, $urandom};
    logic [4:0]  wa  = 5'($urandom);
    logic        rw  = 1'($urandom);
    logic [63:0] exp_res;
    check("in_ready_idle", in_ready, 1);
    drive(kind, sz, uns, pc, addr, wd, wa, rw);
    cycle();
    in_valid = 1'b0;
    if (kind != 0) begin
      for (int i = 0; i <= a_dly; i++) begin
        check("dreq_valid", dreq_valid, 1);
        check("dreq_addr", dreq_addr, addr);
        check("dreq_size", dreq_size, sz);
        check("dreq_strobe", dreq_strobe, (kind == 2) ? m_strobe(addr[2:0], sz) : 8'h00);
        if (kind == 2) check("dreq_data", dreq_data, m_sdata(wd, addr[2:0]));
        if (i == a_dly) begin
          dresp_addr_ok = 1'b1;
          if (d_dly == 0) begin
            dresp_data_ok = 1'b1;
            dresp_data    = rd;
          end
        end
        cycle();
        clear_resp();
      end
      for (int i = 1; i <= d_dly; i++) begin
        check("wait_dreq_valid", dreq_valid, 0);
        check("wait_out_valid", out_valid, 0);
        if (i == d_dly) begin
          dresp_data_ok = 1'b1;
          dresp_data    = rd;
        end
        cycle();
        clear_resp();
      end
    end else begin
      check("alu_no_dreq", dreq_valid, 0);
    end
    exp_res = (kind == 1) ? m_load(rd, addr[2:0], sz, uns) : addr;
    for (int i = 0; i <= bp; i++) begin
      check("out_valid", out_valid, 1);
      check("out_result", out_result, exp_res);
      check("out_pc", out_pc, pc);
      check("out_wa", out_wa, wa);
      check("out_regwrite", out_regwrite, rw);
      check("dreq_idle_done", dreq_valid, 0);
`ifdef MEM_MISALIGN_CHECK_EN
      check("out_misalign_clr", out_misalign, 0);
`endif
      if (i < bp) begin
        check("in_ready_bp", in_ready, 0);
        cycle();
      end
    end
    out_ready = 1'b1;
    #1;
    check("in_ready_release", in_ready, 1);
    cycle();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    $display("txn kind=%0d size=%0d uns=%0d addr=%h result=%h", kind, sz, uns, addr, out_result);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_result = '0; in_wdata = '0; in_wa = '0; in_regwrite = 1'b0;
    in_memread = 1'b0; in_memwrite = 1'b0; in_msize = 2'd0; in_unsigned = 1'b0;
    clear_resp();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_dreq_strobe", dreq_strobe, 0);
    check("rst_in_ready", in_ready, 1);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases from the test plan
    run_txn(0, 2'd3, 1'b0, 64'h1234, 64'h0, 64'h0, 0, 0, 0);
    run_txn(2, 2'd0, 1'b0, 64'h8000_0003, 64'hAB, 64'h0, 2, 2, 0);
    check("store_byte_strobe", m_strobe(3'd3, 2'd0), 8'h08);
    run_txn(1, 2'd1, 1'b0, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 0, 0, 0);
    run_txn(1, 2'd1, 1'b1, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 0, 0, 0);
    run_txn(0, 2'd0, 1'b0, 64'hDEAD_BEEF, 64'h0, 64'h0, 0, 0, 4);

    // Back-to-back accept in DONE
    drive(0, 2'd0, 1'b0, 64'h100, 64'hAAAA, 64'h0, 5'd1, 1'b1);
    cycle();
    drive(0, 2'd0, 1'b0, 64'h104, 64'hBBBB, 64'h0, 5'd2, 1'b1);
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    check("b2b_first_result", out_result, 64'hAAAA);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_out_valid", out_valid, 1);
    check("b2b_second_result", out_result, 64'hBBBB);
    check("b2b_second_pc", out_pc, 64'h104);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("b2b_idle", out_valid, 0);

    // Reset during REQ, then during WAIT with a late data_ok
    drive(1, 2'd3, 1'b0, 64'h200, 64'h40, 64'h0, 5'd3, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("rq_dreq_valid", dreq_valid, 1);
    resetn = 1'b0;
    #1;
    check("rst_req_dreq_valid", dreq_valid, 0);
    check("rst_req_out_valid", out_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 2'd3, 1'b0, 64'h300, 64'h48, 64'h0, 5'd4, 1'b1);
    cycle();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    cycle();
    clear_resp();
    check("wait_state_dreq", dreq_valid, 0);
    resetn = 1'b0;
    #1;
    check("rst_wait_dreq_valid", dreq_valid, 0);
    check("rst_wait_out_valid", out_valid, 0);
    check("rst_wait_in_ready", in_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    dresp_data_ok = 1'b1;
    cycle();
    clear_resp();
    check("late_data_ok_out_valid", out_valid, 0);
    check("late_data_ok_in_ready", in_ready, 1);
    check("late_data_ok_dreq", dreq_valid, 0);

`ifdef MEM_MISALIGN_CHECK_EN
    drive(1, 2'd2, 1'b0, 64'h400, 64'h8000_0002, 64'h0, 5'd6, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("mis_dreq_valid", dreq_valid, 0);
    check("mis_out_valid", out_valid, 1);
    check("mis_flag", out_misalign, 1);
    check("mis_regwrite", out_regwrite, 0);
    check("mis_result", out_result, 64'h8000_0002);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
`endif

    // Randomized aligned transactions
    for (int t = 0; t < 60; t++) begin
      int          kind = $urandom_range(0, 2);
      logic [1:0]  sz   = 2'($urandom_range(0, 3));
      logic [63:0] addr = {$urandom, $urandom};
      addr = addr & ~(64'((1 << sz) - 1));
      run_txn(kind, sz, 1'($urandom), addr, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
